// File: rtl/csr_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : csr_bus_arbiter
//  Purpose  : Shares one CSR bus master port between NUM_REQ requesters, one
//             command in flight, returning read data to the originator.
//             Define CSR_ARB_FIXED_PRI_EN for fixed priority (lowest index
//             wins); otherwise round-robin arbitration is used.
//  Revision : 1.0 - initial release
// ============================================================================
module csr_bus_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ-1:0]         req_write,
    input  logic [NUM_REQ*ADDR_W-1:0]  req_address,
    input  logic [NUM_REQ*DATA_W-1:0]  req_wr_data,
    output logic [NUM_REQ-1:0]         rsp_valid,
    output logic [DATA_W-1:0]          rsp_rd_data,
    output logic [ADDR_W-1:0]          csr_address,
    output logic                       csr_write,
    output logic                       csr_read,
    output logic [DATA_W-1:0]          csr_wr_data,
    input  logic [DATA_W-1:0]          csr_rd_data
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(RD_LATENCY + 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ISSUE   = 2'd1;
    localparam logic [1:0] S_WAIT_RD = 2'd2;
    localparam logic [1:0] S_RESP    = 2'd3;

    logic [1:0]        r_state;
    logic [1:0]        w_next_state;
    logic              r_cmd_write;
    logic [ADDR_W-1:0] r_cmd_addr;
    logic [DATA_W-1:0] r_cmd_data;
    logic [IDX_W-1:0]  r_cmd_idx;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_rd_data;

    logic              w_found;
    logic [IDX_W-1:0]  w_grant_idx;
    logic              w_handshake;

    logic [ADDR_W-1:0] w_addr_arr [NUM_REQ];
    logic [DATA_W-1:0] w_data_arr [NUM_REQ];

    generate
        for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
            assign w_addr_arr[g] = req_address[g*ADDR_W +: ADDR_W];
            assign w_data_arr[g] = req_wr_data[g*DATA_W +: DATA_W];
        end
    endgenerate

`ifdef CSR_ARB_FIXED_PRI_EN
    // Descending scan so the lowest valid index is the final assignment.
    always_comb begin
        w_found     = 1'b0;
        w_grant_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                w_found     = 1'b1;
                w_grant_idx = IDX_W'(i);
            end
        end
    end
`else
    localparam logic [IDX_W:0] C_NUM_REQ = (IDX_W + 1)'(NUM_REQ);

    logic [IDX_W-1:0] r_last;
    logic [IDX_W:0]   w_cand;

    // Scan offsets from farthest to nearest so the nearest one after r_last wins.
    always_comb begin
        w_found     = 1'b0;
        w_grant_idx = '0;
        w_cand      = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_cand = {1'b0, r_last} + (IDX_W + 1)'(k);
            if (w_cand >= C_NUM_REQ) begin
                w_cand = w_cand - C_NUM_REQ;
            end
            if (req_valid[w_cand[IDX_W-1:0]]) begin
                w_found     = 1'b1;
                w_grant_idx = w_cand[IDX_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last <= IDX_W'(NUM_REQ - 1);
        end else if (w_handshake) begin
            r_last <= w_grant_idx;
        end
    end
`endif

    assign w_handshake = (r_state == S_IDLE) && w_found;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:    if (w_handshake) w_next_state = S_ISSUE;
            S_ISSUE:   w_next_state = r_cmd_write ? S_RESP : S_WAIT_RD;
            S_WAIT_RD: if (r_cnt == CNT_W'(1)) w_next_state = S_RESP;
            S_RESP:    w_next_state = S_IDLE;
            default:   w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cmd_write <= 1'b0;
            r_cmd_addr  <= '0;
            r_cmd_data  <= '0;
            r_cmd_idx   <= '0;
            r_cnt       <= '0;
            r_rd_data   <= '0;
        end else begin
            if (w_handshake) begin
                r_cmd_write <= req_write[w_grant_idx];
                r_cmd_addr  <= w_addr_arr[w_grant_idx];
                r_cmd_data  <= w_data_arr[w_grant_idx];
                r_cmd_idx   <= w_grant_idx;
                r_rd_data   <= '0;
            end
            if (r_state == S_ISSUE) begin
                r_cnt <= CNT_W'(RD_LATENCY);
            end
            // Read data is valid RD_LATENCY cycles after the strobe cycle.
            if (r_state == S_WAIT_RD) begin
                r_cnt <= r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    r_rd_data <= csr_rd_data;
                end
            end
        end
    end

    // Ready is masked while reset is held so all outputs read zero in reset.
    always_comb begin
        req_ready   = '0;
        rsp_valid   = '0;
        rsp_rd_data = '0;
        csr_write   = 1'b0;
        csr_read    = 1'b0;
        if (reset_n && (r_state == S_IDLE) && w_found) begin
            req_ready[w_grant_idx] = 1'b1;
        end
        if (r_state == S_ISSUE) begin
            csr_write = r_cmd_write;
            csr_read  = !r_cmd_write;
        end
        if (r_state == S_RESP) begin
            rsp_valid[r_cmd_idx] = 1'b1;
            rsp_rd_data          = r_rd_data;
        end
    end

    assign csr_address = r_cmd_addr;
    assign csr_wr_data = r_cmd_data;

endmodule
`default_nettype wire

// File: tb/tb_csr_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_csr_bus_arbiter
//  Purpose  : Scoreboard bench for csr_bus_arbiter with a CSR slave model and
//             a transaction-level reference model of arbitration and timing.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_csr_bus_arbiter;

    localparam int NR  = 2;
    localparam int AW  = 8;
    localparam int DW  = 32;
    localparam int LAT = 3;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR-1:0]     req_write;
    logic [NR*AW-1:0]  req_address;
    logic [NR*DW-1:0]  req_wr_data;
    logic [NR-1:0]     rsp_valid;
    logic [DW-1:0]     rsp_rd_data;
    logic [AW-1:0]     csr_address;
    logic              csr_write;
    logic              csr_read;
    logic [DW-1:0]     csr_wr_data;
    logic [DW-1:0]     csr_rd_data;

    always #5 clk = ~clk;

    csr_bus_arbiter #(
        .NUM_REQ    (NR),
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .RD_LATENCY (LAT)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_address (req_address),
        .req_wr_data (req_wr_data),
        .rsp_valid   (rsp_valid),
        .rsp_rd_data (rsp_rd_data),
        .csr_address (csr_address),
        .csr_write   (csr_write),
        .csr_read    (csr_read),
        .csr_wr_data (csr_wr_data),
        .csr_rd_data (csr_rd_data)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // CSR slave: read data appears exactly LAT cycles after the strobe cycle.
    logic [DW-1:0] slv_mem [256];
    logic [DW-1:0] rd_pipe [LAT];
    always @(posedge clk) begin
        if (csr_write) slv_mem[csr_address] <= csr_wr_data;
        rd_pipe[0] <= csr_read ? slv_mem[csr_address] : DW'($urandom);
        for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign csr_rd_data = rd_pipe[LAT-1];

    typedef struct { int cyc; bit wr; logic [AW-1:0] addr; logic [DW-1:0] data; } bus_t;
    typedef struct { int cyc; int idx; logic [DW-1:0] data; } rsp_t;

    bus_t          bus_q [$];
    rsp_t          rsp_q [$];
    logic [DW-1:0] ref_mem [256];
    int            m_last = NR - 1;
    int            busy_until = 0;
    logic [NR-1:0] hs = '0;

    function automatic int pick(input logic [NR-1:0] v);
`ifdef CSR_ARB_FIXED_PRI_EN
        for (int i = 0; i < NR; i++) if (v[i]) return i;
`else
        for (int k = 1; k <= NR; k++) if (v[(m_last + k) % NR]) return (m_last + k) % NR;
`endif
        return -1;
    endfunction

    always @(negedge clk) begin
        int            w;
        logic [NR-1:0] exp_ready;
        logic [NR-1:0] exp_onehot;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        bit            exp_strobe;
        bit            exp_rsp;
        bus_t          b;
        rsp_t          r;
        if (!reset_n) begin
            vectors++;
            if (req_ready != 0 || rsp_valid != 0 || csr_write || csr_read ||
                csr_address != 0 || csr_wr_data != 0 || rsp_rd_data != 0) begin
                miscompares++;
                $display("FAIL reset_outputs: ready=%b rsp=%b wr=%b rd=%b addr=%h wdata=%h rdata=%h, required all zero",
                         req_ready, rsp_valid, csr_write, csr_read, csr_address, csr_wr_data, rsp_rd_data);
            end
            bus_q.delete();
            rsp_q.delete();
            m_last     = NR - 1;
            busy_until = 0;
            hs         = '0;
        end else begin
            w = (cyc >= busy_until) ? pick(req_valid) : -1;
            exp_ready = '0;
            if (w >= 0) exp_ready[w] = 1'b1;
            vectors++;
            if (req_ready !== exp_ready) begin
                miscompares++;
                $display("FAIL req_ready @%0d: got %b, expected %b (valid=%b)", cyc, req_ready, exp_ready, req_valid);
            end
            hs = req_valid & req_ready;
            if (w >= 0) begin
                a = req_address[w*AW +: AW];
                d = req_wr_data[w*DW +: DW];
                bus_q.push_back('{cyc + 1, req_write[w], a, d});
                if (req_write[w]) begin
                    ref_mem[a] = d;
                    rsp_q.push_back('{cyc + 2, w, '0});
                    busy_until = cyc + 3;
                end else begin
                    rsp_q.push_back('{cyc + 2 + LAT, w, ref_mem[a]});
                    busy_until = cyc + 3 + LAT;
                end
                m_last = w;
            end

            exp_strobe = (bus_q.size() > 0) && (bus_q[0].cyc == cyc);
            if (exp_strobe || csr_write || csr_read) begin
                vectors++;
                if (!exp_strobe) begin
                    miscompares++;
                    $display("FAIL bus_strobe @%0d: got wr=%b rd=%b, expected no strobe", cyc, csr_write, csr_read);
                end else begin
                    b = bus_q.pop_front();
                    if (csr_write !== b.wr || csr_read !== !b.wr || csr_address !== b.addr ||
                        (b.wr && csr_wr_data !== b.data)) begin
                        miscompares++;
                        $display("FAIL bus_cmd @%0d: got wr=%b rd=%b addr=%h data=%h, expected wr=%b addr=%h data=%h",
                                 cyc, csr_write, csr_read, csr_address, csr_wr_data, b.wr, b.addr, b.data);
                    end
                end
            end

            exp_rsp = (rsp_q.size() > 0) && (rsp_q[0].cyc == cyc);
            if (exp_rsp || rsp_valid != 0) begin
                vectors++;
                if (!exp_rsp) begin
                    miscompares++;
                    $display("FAIL rsp_unexpected @%0d: got rsp_valid=%b, expected 0", cyc, rsp_valid);
                end else begin
                    r = rsp_q.pop_front();
                    exp_onehot = '0;
                    exp_onehot[r.idx] = 1'b1;
                    if (rsp_valid !== exp_onehot || rsp_rd_data !== r.data) begin
                        miscompares++;
                        $display("FAIL rsp @%0d: got valid=%b data=%h, expected valid=%b data=%h",
                                 cyc, rsp_valid, rsp_rd_data, exp_onehot, r.data);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input int i, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_write[i]           = wr;
        req_address[i*AW +: AW] = a;
        req_wr_data[i*DW +: DW] = d;
        req_valid[i]           = 1'b1;
    endtask

    task automatic issue(input int i, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        set_cmd(i, wr, a, d);
        for (int t = 0; t < 100; t++) begin
            tick();
            if (hs[i]) break;
        end
        vectors++;
        if (!hs[i]) begin
            miscompares++;
            $display("FAIL issue_timeout: requester %0d got no ready, expected a grant", i);
        end
        req_valid[i] = 1'b0;
    endtask

    task automatic run_random(input int cycles, input int p_new, input int p_drop);
        bit withdrawn;
        repeat (cycles) begin
            tick();
            for (int i = 0; i < NR; i++) begin
                withdrawn = 1'b0;
                if (hs[i]) begin
                    req_valid[i] = 1'b0;
                end else if (req_valid[i] && $urandom_range(0, 99) < p_drop) begin
                    req_valid[i] = 1'b0;
                    withdrawn    = 1'b1;
                end
                if (!req_valid[i] && !withdrawn && $urandom_range(0, 99) < p_new)
                    set_cmd(i, 1'($urandom), AW'($urandom_range(0, 15)), DW'($urandom));
            end
        end
        req_valid = '0;
    endtask

    initial begin
        logic [NR-1:0] first_hs;
        for (int i = 0; i < 256; i++) begin
            slv_mem[i] = DW'(i) * 32'h0101_0101 ^ 32'hA5A5_A5A5;
            ref_mem[i] = DW'(i) * 32'h0101_0101 ^ 32'hA5A5_A5A5;
        end
        slv_mem[4] = 32'h1234_5678;
        ref_mem[4] = 32'h1234_5678;
        for (int i = 0; i < LAT; i++) rd_pipe[i] = '0;
        req_valid   = '0;
        req_write   = '0;
        req_address = '0;
        req_wr_data = '0;
        reset_n     = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        tick();

        issue(0, 1'b1, 8'h10, 32'hDEAD_BEEF);
        repeat (6) tick();
        issue(1, 1'b0, 8'h04, 32'h0);
        repeat (8) tick();
        issue(0, 1'b0, 8'h10, 32'h0);
        repeat (8) tick();

        run_random(120, 100, 0);
        repeat (10) tick();
        run_random(2000, 30, 8);
        repeat (20) tick();

        // A one-cycle request during another command's strobe must never be granted.
        issue(0, 1'b1, 8'h20, 32'hCAFE_F00D);
        set_cmd(1, 1'b1, 8'h21, 32'h1111_2222);
        tick();
        req_valid[1] = 1'b0;
        repeat (10) tick();

        // Reset while a read waits on the bus; afterwards requester 0 goes first.
        issue(0, 1'b0, 8'h04, 32'h0);
        tick();
        reset_n = 1'b0;
        set_cmd(0, 1'b1, 8'h30, 32'h3030_3030);
        set_cmd(1, 1'b1, 8'h31, 32'h3131_3131);
        repeat (2) tick();
        reset_n = 1'b1;
        first_hs = '0;
        for (int t = 0; t < 20 && first_hs == 0; t++) begin
            tick();
            first_hs = hs;
        end
        vectors++;
        if (first_hs !== 2'b01) begin
            miscompares++;
            $display("FAIL post_reset_first_grant: got %b, expected 01", first_hs);
        end
        req_valid[0] = 1'b0;
        for (int t = 0; t < 40 && !hs[1]; t++) tick();
        req_valid = '0;
        repeat (20) tick();

        vectors++;
        if (bus_q.size() != 0 || rsp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d bus and %0d rsp pending, expected 0 and 0", bus_q.size(), rsp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
